// File: rtl/datapath_core.sv
// datapath_core: single-cycle 8-bit datapath. One instruction per rising edge,
// 4x8 register file, 256x8 data memory and an 8-bit hex display latch.
module datapath_core (
    input  logic       _CLK,
    input  logic       RESET,
    input  logic [7:0] instruction,
    output logic [7:0] PC,
    output logic [3:0] m,
    output logic [3:0] l
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_J   = 2'b11
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [1:0] rd;
    } instr_t;

    instr_t     ins;
    logic [7:0] regs [4];
    logic [7:0] mem  [256];
    logic [7:0] disp;

    logic [7:0] rs_val, rt_val, imm2_sext, imm6_sext;
    logic [7:0] addr, sum, ld_val, pc_inc;
    logic [7:0] pc_nxt, disp_nxt;
    logic       reg_we, mem_we;
    logic [1:0] reg_wa;
    logic [7:0] reg_wd;

    assign ins = instr_t'(instruction);

    // Combinational operand fetch: reads see pre-edge state, so ADD r1=r1+r1 doubles old r1
    always_comb begin
        rs_val    = regs[ins.rs];
        rt_val    = regs[ins.rt];
        imm2_sext = {{6{instruction[1]}}, instruction[1:0]};
        imm6_sext = {{2{instruction[5]}}, instruction[5:0]};
        addr      = rs_val + imm2_sext;
        sum       = rs_val + rt_val;
        ld_val    = mem[addr];
        pc_inc    = PC + 8'd1;
    end

    // Decode: next PC, display value and write enables for this instruction
    always_comb begin
        pc_nxt   = pc_inc;
        disp_nxt = disp;
        reg_we   = 1'b0;
        mem_we   = 1'b0;
        reg_wa   = ins.rd;
        reg_wd   = sum;
        unique case (ins.op)
            OP_ADD: begin
                reg_we   = 1'b1;
                disp_nxt = sum;
            end
            OP_LW: begin
                reg_we   = 1'b1;
                reg_wa   = ins.rt;
                reg_wd   = ld_val;
                disp_nxt = ld_val;
            end
            OP_SW: begin
                mem_we   = 1'b1;
                disp_nxt = rt_val;
            end
            OP_J: begin
                pc_nxt = pc_inc + imm6_sext;
            end
            default: ;
        endcase
    end

    // PC, display and register file update; reset clears all to zero
    always_ff @(posedge _CLK) begin
        if (RESET) begin
            PC   <= 8'h00;
            disp <= 8'h00;
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else begin
            PC   <= pc_nxt;
            disp <= disp_nxt;
            if (reg_we) regs[reg_wa] <= reg_wd;
        end
    end

    // Data memory: reset reloads the identity pattern MEM[i] = i
    always_ff @(posedge _CLK) begin
        if (RESET) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (mem_we) begin
            mem[addr] <= rt_val;
        end
    end

    assign m = disp[7:4];
    assign l = disp[3:0];

endmodule

// File: tb/tb_datapath_core.sv
// Scoreboard bench for datapath_core: each driven edge pushes the expected
// {PC, m, l}; a negedge monitor pops and compares. Test tasks add direct
// checks against hand-derived values.
module tb_datapath_core;

    logic       _CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] instruction = 8'h00;
    logic [7:0] PC;
    logic [3:0] m, l;

    int errors = 0;
    int checks = 0;

    logic [15:0] sb_q [$];

    // reference state
    logic [7:0] r_m   [4];
    logic [7:0] mem_m [256];
    logic [7:0] pc_m, disp_m;

    datapath_core dut (
        ._CLK        (_CLK),
        .RESET       (RESET),
        .instruction (instruction),
        .PC          (PC),
        .m           (m),
        .l           (l)
    );

    always #5 _CLK = ~_CLK;

    // scoreboard monitor: compare one expected entry per executed edge
    always @(negedge _CLK) begin
        if (sb_q.size() > 0) begin
            logic [15:0] exp_v;
            exp_v = sb_q.pop_front();
            checks++;
            if ({PC, m, l} !== exp_v) begin
                errors++;
                $display("FAIL scoreboard: got PC=%h ml=%h%h expected PC=%h ml=%h", PC, m, l, exp_v[15:8], exp_v[7:0]);
            end
        end
    end

    // drive one edge, update the model, push the expected outputs
    task automatic step(input logic rst, input logic [7:0] ins);
        logic [7:0] a, b, addr, v;
        RESET = rst;
        instruction = ins;
        if (rst) begin
            pc_m = 8'h00;
            disp_m = 8'h00;
            for (int i = 0; i < 4; i++) r_m[i] = 8'h00;
            for (int i = 0; i < 256; i++) mem_m[i] = 8'(i);
        end else begin
            a = r_m[ins[5:4]];
            b = r_m[ins[3:2]];
            addr = a + {{6{ins[1]}}, ins[1:0]};
            case (ins[7:6])
                2'b00: begin v = a + b; r_m[ins[1:0]] = v; disp_m = v; pc_m = pc_m + 8'd1; end
                2'b01: begin v = mem_m[addr]; r_m[ins[3:2]] = v; disp_m = v; pc_m = pc_m + 8'd1; end
                2'b10: begin mem_m[addr] = b; disp_m = b; pc_m = pc_m + 8'd1; end
                default: pc_m = pc_m + 8'd1 + {{2{ins[5]}}, ins[5:0]};
            endcase
        end
        sb_q.push_back({pc_m, disp_m});
        @(posedge _CLK);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 8'hC3);
        step(1'b1, 8'hC3);
        checks++;
        if ({PC, m, l} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: got PC=%h m=%h l=%h expected 00 0 0", PC, m, l);
        end
        // SW MEM[r0] <- rX shows R[X] on the display
        for (int x = 0; x < 4; x++) begin
            step(1'b0, 8'h80 | 8'(x << 2));
            checks++;
            if ({m, l} !== 8'h00 || PC !== 8'(x + 1)) begin
                errors++;
                $display("FAIL reset_reg%0d: got PC=%h ml=%h%h expected PC=%h ml=00", x, PC, m, l, 8'(x + 1));
            end
        end
    endtask

    task automatic test_load_wrap();
        step(1'b1, 8'h00);
        step(1'b0, 8'h45);
        checks++;
        if ({PC, m, l} !== 16'h0101) begin
            errors++;
            $display("FAIL lw_plus1: got PC=%h ml=%h%h expected PC=01 ml=01", PC, m, l);
        end
        step(1'b0, 8'h4B);
        checks++;
        if ({PC, m, l} !== 16'h02FF) begin
            errors++;
            $display("FAIL lw_wrap_ff: got PC=%h ml=%h%h expected PC=02 ml=ff", PC, m, l);
        end
    endtask

    task automatic test_add_overflow();
        step(1'b0, 8'h2B);
        checks++;
        if ({m, l} !== 8'hFE) begin
            errors++;
            $display("FAIL add_double: got ml=%h%h expected fe", m, l);
        end
        step(1'b0, 8'h1B);
        checks++;
        if ({PC, m, l} !== 16'h0400) begin
            errors++;
            $display("FAIL add_overflow: got PC=%h ml=%h%h expected PC=04 ml=00", PC, m, l);
        end
    endtask

    task automatic test_store_load();
        step(1'b1, 8'h00);
        step(1'b0, 8'h45);
        step(1'b0, 8'h4B);
        step(1'b0, 8'h2B);
        step(1'b0, 8'h9C);
        checks++;
        if ({PC, m, l} !== 16'h04FE) begin
            errors++;
            $display("FAIL sw_display: got PC=%h ml=%h%h expected PC=04 ml=fe", PC, m, l);
        end
        // jump from PC=4 before the reload: display must hold FE
        step(1'b0, 8'hC3);
        checks++;
        if ({PC, m, l} !== 16'h08FE) begin
            errors++;
            $display("FAIL j_plus3: got PC=%h ml=%h%h expected PC=08 ml=fe", PC, m, l);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'hFF);
            checks++;
            if (PC !== 8'h08) begin
                errors++;
                $display("FAIL j_selfloop%0d: got PC=%h expected 08", k, PC);
            end
        end
        step(1'b0, 8'h50);
        checks++;
        if ({m, l} !== 8'hFE) begin
            errors++;
            $display("FAIL lw_roundtrip: got ml=%h%h expected fe", m, l);
        end
        // r0 now FE: r0 + r0 = FC
        step(1'b0, 8'h00);
        checks++;
        if ({m, l} !== 8'hFC) begin
            errors++;
            $display("FAIL r0_writable: got ml=%h%h expected fc", m, l);
        end
    endtask

    task automatic test_jump_wrap();
        step(1'b1, 8'h00);
        for (int k = 0; k < 5; k++) step(1'b0, 8'h00);
        step(1'b0, 8'hE0);
        checks++;
        if (PC !== 8'hE6) begin
            errors++;
            $display("FAIL j_minus32: got PC=%h expected e6", PC);
        end
        step(1'b0, 8'hD8);
        checks++;
        if (PC !== 8'hFF) begin
            errors++;
            $display("FAIL j_to_ff: got PC=%h expected ff", PC);
        end
        for (int k = 0; k < 255; k++) begin
            step(1'b0, {2'b00, 6'($urandom_range(0, 63))});
            if (k == 0) begin
                checks++;
                if (PC !== 8'h00) begin
                    errors++;
                    $display("FAIL pc_wrap: got PC=%h expected 00", PC);
                end
            end
        end
        checks++;
        if (PC !== 8'hFE) begin
            errors++;
            $display("FAIL pc_after_255: got PC=%h expected fe", PC);
        end
    endtask

    task automatic test_random();
        step(1'b1, 8'h00);
        for (int k = 0; k < 400; k++) step(1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic test_mid_reset();
        step(1'b1, 8'h00);
        step(1'b0, 8'h45);
        step(1'b0, 8'h4B);
        step(1'b0, 8'h2B);
        step(1'b0, 8'h9C);
        step(1'b1, 8'h9C);
        checks++;
        if ({PC, m, l} !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: got PC=%h ml=%h%h expected PC=00 ml=00", PC, m, l);
        end
        step(1'b0, 8'h45);
        checks++;
        if ({PC, m, l} !== 16'h0101) begin
            errors++;
            $display("FAIL mem_restored: got PC=%h ml=%h%h expected PC=01 ml=01", PC, m, l);
        end
    endtask

    initial begin
        test_reset();
        test_load_wrap();
        test_add_overflow();
        test_store_load();
        test_jump_wrap();
        test_random();
        test_mid_reset();
        @(negedge _CLK);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
